pim_psum_collector: RTL

- Output-side partner of the bit-serial PIM convolution unit.
- Per bit cycle, accepts the four crossbar ADC partial sums (HH, HL, LH, LL) and weights each by its half-word and input bit position.
- Accumulates them over the INPUT_P/2 bit beats of one crossbar address, then presents the reconstructed product sum per address through a valid/ready output.
- One run covers DEPTH addresses, started by `start` and closed by a one-cycle `done` pulse.

---
 rtl/pim_pkg.sv | 37 +++
 rtl/pim_bit_weight.sv | 31 +++
 rtl/pim_psum_collector.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pim_pkg.sv
// pim_pkg: shared helpers, FSM state type and shift constants for the PIM datapath. Rev 1.0
`default_nettype none
package pim_pkg;

    // Ceiling log2, never narrower than one bit so it can size a port.
    function automatic int clogb2(input int value);
        int width;
        int v;
        width = 0;
        v     = value - 1;
        while (v > 0) begin
            width++;
            v = v >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int sh_hh(input int input_p);
        return input_p;
    endfunction

    function automatic int sh_mid(input int input_p);
        return input_p / 2;
    endfunction

    localparam int DEF_INPUT_P = 16;
    localparam int SH_HH       = sh_hh(DEF_INPUT_P);
    localparam int SH_MID      = sh_mid(DEF_INPUT_P);

endpackage
`default_nettype wire

// File: rtl/pim_bit_weight.sv
// pim_bit_weight: weights the four ADC partial sums of one bit beat and shifts by the bit index. Rev 1.0
`default_nettype none
module pim_bit_weight
    import pim_pkg::*;
#(
    parameter int INPUT_P = DEF_INPUT_P,
    parameter int ADC_P   = 8,
    parameter int ACC_W   = 34,
    parameter int BIT_W   = 3
) (
    input  logic [ADC_P-1:0] hh,
    input  logic [ADC_P-1:0] hl,
    input  logic [ADC_P-1:0] lh,
    input  logic [ADC_P-1:0] ll,
    input  logic [BIT_W-1:0] bit_idx,
    output logic [ACC_W-1:0] term
);

    localparam int SHIFT_HH  = sh_hh(INPUT_P);
    localparam int SHIFT_MID = sh_mid(INPUT_P);

    logic [ACC_W-1:0] base;

    // The two cross half-word products share the same weight, so they are summed before shifting.
    assign base = (ACC_W'(hh) << SHIFT_HH)
                + ((ACC_W'(hl) + ACC_W'(lh)) << SHIFT_MID)
                + ACC_W'(ll);
    assign term = base << bit_idx;

endmodule
`default_nettype wire

// File: rtl/pim_psum_collector.sv
// pim_psum_collector: accumulates bit-serial crossbar partial sums into one product sum per address.
// Optional macro PSUM_SAT_EN saturates out_data instead of wrapping. Rev 1.0
`default_nettype none
module pim_psum_collector
    import pim_pkg::*;
#(
    parameter int  INPUT_P = 16,
    parameter int  ADC_P   = 8,
    parameter int  DEPTH   = 100,
    parameter int  OUT_P   = 32,
    localparam int ADDR_W  = clogb2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADC_P-1:0]  in_hh,
    input  logic [ADC_P-1:0]  in_hl,
    input  logic [ADC_P-1:0]  in_lh,
    input  logic [ADC_P-1:0]  in_ll,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_P-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int BITS  = INPUT_P / 2;
    localparam int BIT_W = clogb2(BITS);
    localparam int ACC_W = ADC_P + INPUT_P + BITS + 2;

    state_t            state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              all_loaded;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  term;
    logic [ACC_W-1:0]  acc_sum;
    logic [OUT_P-1:0]  result;
    logic              last_beat;
    logic              accept;

    pim_bit_weight #(
        .INPUT_P (INPUT_P),
        .ADC_P   (ADC_P),
        .ACC_W   (ACC_W),
        .BIT_W   (BIT_W)
    ) u_bit_weight (
        .hh      (in_hh),
        .hl      (in_hl),
        .lh      (in_lh),
        .ll      (in_ll),
        .bit_idx (bit_cnt),
        .term    (term)
    );

    assign last_beat = (bit_cnt == BIT_W'(BITS - 1));
    // Built from registered state only, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (state == RUN) && !(last_beat && out_valid) && !all_loaded;
    assign accept    = in_valid && in_ready;
    assign acc_sum   = acc + term;

`ifdef PSUM_SAT_EN
    generate
        if (ACC_W > OUT_P) begin : g_sat
            assign result = (|acc_sum[ACC_W-1:OUT_P]) ? '1 : acc_sum[OUT_P-1:0];
        end else begin : g_sat_wide
            assign result = OUT_P'(acc_sum);
        end
    endgenerate
`else
    assign result = OUT_P'(acc_sum);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            addr_cnt   <= '0;
            all_loaded <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                        addr_cnt   <= '0;
                        all_loaded <= 1'b0;
                        acc        <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            out_valid <= 1'b1;
                            out_data  <= result;
                            out_addr  <= addr_cnt;
                            out_last  <= (addr_cnt == ADDR_W'(DEPTH - 1));
                            acc       <= '0;
                            bit_cnt   <= '0;
                            if (addr_cnt == ADDR_W'(DEPTH - 1)) begin
                                all_loaded <= 1'b1;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end else begin
                            acc     <= acc_sum;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // The run closes only once the final address has been handed off downstream.
                    if (all_loaded && out_valid && out_ready) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
